// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, counter
// width, parameter defaults and a small saturating-increment helper.
package pll_rst_pkg;

    // Width of the single shared sequencing counter.
    localparam int CNT_W = 20;

    // Width of the lock-loss counter reported to software.
    localparam int RELOCK_W = 8;

    // Parameter defaults for pll_rst_seq.
    localparam int unsigned LOCK_STABLE_DEF    = 1024;
    localparam int unsigned STAGE_GAP_DEF      = 256;
    localparam int unsigned LOCK_TIMEOUT_DEF   = 1048576;
    localparam int unsigned PLL_RST_CYCLES_DEF = 16;

    typedef logic [CNT_W-1:0]    cnt_t;
    typedef logic [RELOCK_W-1:0] relock_t;

    // Sequencer states, in release order.
    typedef enum logic [2:0] {
        S_PLLRST = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_MEM    = 3'd3,
        S_CORE   = 3'd4,
        S_RUN    = 3'd5
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic relock_t sat_inc(input relock_t v);
        if (v == {RELOCK_W{1'b1}}) begin
            return v;
        end
        return v + relock_t'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Both flops clear to 0 while rst_n is low.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; second flop gives it a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the memory, core and CPU resets in that order with a fixed gap.
// Lock loss re-asserts everything; a soft reset re-runs only core and CPU.
// Every output is a registered decode of the next state, so each reset
// changes on the same edge as the state transition that owns it.
// All counting parameters must be at least 1.
module pll_rst_seq
    import pll_rst_pkg::*;
#(
    parameter int unsigned LOCK_STABLE    = LOCK_STABLE_DEF,
    parameter int unsigned STAGE_GAP      = STAGE_GAP_DEF,
    parameter int unsigned LOCK_TIMEOUT   = LOCK_TIMEOUT_DEF,
    parameter int unsigned PLL_RST_CYCLES = PLL_RST_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       sw_rst_req,
    output logic       pll_rst,
    output logic       rst_mem_n,
    output logic       rst_core_n,
    output logic       rst_cpu_n,
    output logic       ready,
    output logic [7:0] relock_cnt
);

    // Terminal counts: a state that must last N cycles leaves when cnt_q == N-1.
    localparam cnt_t PLL_LAST     = cnt_t'(PLL_RST_CYCLES - 1);
    localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT - 1);
    localparam cnt_t STABLE_LAST  = cnt_t'(LOCK_STABLE - 1);
    localparam cnt_t GAP_LAST     = cnt_t'(STAGE_GAP - 1);

    logic    locked_s;
    state_e  state_q, state_d;
    cnt_t    cnt_q, cnt_d;
    logic    pll_rst_q, pll_rst_d;
    logic    mem_n_q, mem_n_d;
    logic    core_n_q, core_n_d;
    logic    cpu_n_q, cpu_n_d;
    logic    ready_q, ready_d;
    relock_t relock_q, relock_d;

    // The only consumer of the raw locked input.
    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (locked),
        .q_o   (locked_s)
    );

    // Next-state logic; lock loss outranks soft reset wherever both apply.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_PLLRST: begin
                if (cnt_q == PLL_LAST) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_PLLRST;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_d = S_WAIT;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                if (!locked_s) begin
                    state_d = S_WAIT;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = S_CORE;
                end
            end
            S_CORE: begin
                if (!locked_s) begin
                    state_d = S_WAIT;
                end else if (sw_rst_req) begin
                    state_d = S_MEM;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d = S_WAIT;
                end else if (sw_rst_req) begin
                    state_d = S_MEM;
                end
            end
            default: begin
                state_d = S_PLLRST;
            end
        endcase
    end

    // Shared counter: restarts on every state change, idles in S_RUN.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + cnt_t'(1);
        end
    end

    // Output decode from the next state; nested state sets enforce mem < core < cpu.
    always_comb begin
        pll_rst_d = (state_d == S_PLLRST);
        mem_n_d   = (state_d == S_MEM) || (state_d == S_CORE) || (state_d == S_RUN);
        core_n_d  = (state_d == S_CORE) || (state_d == S_RUN);
        cpu_n_d   = (state_d == S_RUN);
        ready_d   = (state_d == S_RUN);
    end

    // Count lock losses taken from S_RUN, including when a soft reset collides.
    always_comb begin
        relock_d = relock_q;
        if ((state_q == S_RUN) && !locked_s) begin
            relock_d = sat_inc(relock_q);
        end
    end

    // State, counter and output registers; reset holds everything in PLL reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_PLLRST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            mem_n_q   <= 1'b0;
            core_n_q  <= 1'b0;
            cpu_n_q   <= 1'b0;
            ready_q   <= 1'b0;
            relock_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst_q <= pll_rst_d;
            mem_n_q   <= mem_n_d;
            core_n_q  <= core_n_d;
            cpu_n_q   <= cpu_n_d;
            ready_q   <= ready_d;
            relock_q  <= relock_d;
        end
    end

    assign pll_rst    = pll_rst_q;
    assign rst_mem_n  = mem_n_q;
    assign rst_core_n = core_n_q;
    assign rst_cpu_n  = cpu_n_q;
    assign ready      = ready_q;
    assign relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with short timing parameters.
// Edge numbers below count rising edges after rst_n is released (first = 1);
// outputs are sampled 1 time unit after each rising edge.
module tb_pll_rst_seq;

    localparam int LS  = 8;
    localparam int SG  = 4;
    localparam int LT  = 64;
    localparam int PRC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       locked;
    logic       sw_rst_req;
    logic       pll_rst;
    logic       rst_mem_n;
    logic       rst_core_n;
    logic       rst_cpu_n;
    logic       ready;
    logic [7:0] relock_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pll_rst_seq #(
        .LOCK_STABLE    (LS),
        .STAGE_GAP      (SG),
        .LOCK_TIMEOUT   (LT),
        .PLL_RST_CYCLES (PRC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .locked     (locked),
        .sw_rst_req (sw_rst_req),
        .pll_rst    (pll_rst),
        .rst_mem_n  (rst_mem_n),
        .rst_core_n (rst_core_n),
        .rst_cpu_n  (rst_cpu_n),
        .ready      (ready),
        .relock_cnt (relock_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves rst_n released just after a rising edge, so the next edge is edge 1.
    task automatic apply_reset();
        rst_n = 1'b0;
        sw_rst_req = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic boot_to_run();
        locked = 1'b1;
        apply_reset();
        repeat (25) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        locked = 1'b1;
        sw_rst_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); end
        n_tests++; if (rst_mem_n !== 1'b0) begin n_fail++; $display("FAIL reset_mem: got %b expected 0", rst_mem_n); end
        n_tests++; if (rst_core_n !== 1'b0) begin n_fail++; $display("FAIL reset_core: got %b expected 0", rst_core_n); end
        n_tests++; if (rst_cpu_n !== 1'b0) begin n_fail++; $display("FAIL reset_cpu: got %b expected 0", rst_cpu_n); end
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
        n_tests++; if (relock_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_relock: got %0d expected 0", relock_cnt); end
        repeat (3) step();
        n_tests++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_hold: got %b expected 1", pll_rst); end
    endtask

    // Locked held high: PLL reset for 4 cycles, 8 stable cycles, then 4-cycle stage gaps.
    // Optionally pulses sw_rst_req in PLLRST, WAIT, STABLE and MEM, which must change nothing.
    task automatic test_cold_boot(input bit with_sw);
        int t_pll, t_mem, t_core, t_cpu, t_rdy, bad;
        t_pll = -1; t_mem = -1; t_core = -1; t_cpu = -1; t_rdy = -1; bad = 0;
        locked = 1'b1;
        apply_reset();
        for (int i = 1; i <= 30; i++) begin
            step();
            if (t_pll < 0 && !pll_rst) t_pll = i;
            if (t_pll >= 0 && pll_rst) bad++;
            if (t_mem < 0 && rst_mem_n) t_mem = i;
            if (t_core < 0 && rst_core_n) t_core = i;
            if (t_cpu < 0 && rst_cpu_n) t_cpu = i;
            if (t_rdy < 0 && ready) t_rdy = i;
            if ((rst_core_n && !rst_mem_n) || (rst_cpu_n && !rst_core_n)) bad++;
            sw_rst_req = with_sw && (i == 1 || i == 4 || i == 6 || i == 14);
        end
        sw_rst_req = 1'b0;
        n_tests++; if (t_pll !== 4) begin n_fail++; $display("FAIL boot_pll_fall(sw=%0d): got edge %0d expected 4", with_sw, t_pll); end
        n_tests++; if (t_mem !== 13) begin n_fail++; $display("FAIL boot_mem_rise(sw=%0d): got edge %0d expected 13", with_sw, t_mem); end
        n_tests++; if (t_core !== 17) begin n_fail++; $display("FAIL boot_core_rise(sw=%0d): got edge %0d expected 17", with_sw, t_core); end
        n_tests++; if (t_cpu !== 21) begin n_fail++; $display("FAIL boot_cpu_rise(sw=%0d): got edge %0d expected 21", with_sw, t_cpu); end
        n_tests++; if (t_rdy !== 21) begin n_fail++; $display("FAIL boot_ready_rise(sw=%0d): got edge %0d expected 21", with_sw, t_rdy); end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL boot_order(sw=%0d): got %0d violations expected 0", with_sw, bad); end
    endtask

    // Locked held low: PLL reset re-pulses every 4 + 64 cycles and nothing is released.
    task automatic test_lock_timeout();
        int fall[2];
        int rise[2];
        int nf, nr, rel;
        logic prev;
        nf = 0; nr = 0; rel = 0; prev = 1'b1;
        fall[0] = -1; fall[1] = -1; rise[0] = -1; rise[1] = -1;
        locked = 1'b0;
        apply_reset();
        for (int i = 1; i <= 145; i++) begin
            step();
            if (prev && !pll_rst && nf < 2) begin fall[nf] = i; nf++; end
            if (!prev && pll_rst && nr < 2) begin rise[nr] = i; nr++; end
            prev = pll_rst;
            if (rst_mem_n || rst_core_n || rst_cpu_n || ready) rel++;
        end
        n_tests++; if (fall[0] !== 4) begin n_fail++; $display("FAIL timeout_fall0: got edge %0d expected 4", fall[0]); end
        n_tests++; if (rise[0] !== 68) begin n_fail++; $display("FAIL timeout_rise0: got edge %0d expected 68", rise[0]); end
        n_tests++; if (fall[1] !== 72) begin n_fail++; $display("FAIL timeout_fall1: got edge %0d expected 72", fall[1]); end
        n_tests++; if (rise[1] !== 136) begin n_fail++; $display("FAIL timeout_rise1: got edge %0d expected 136", rise[1]); end
        n_tests++; if (rel !== 0) begin n_fail++; $display("FAIL timeout_release: got %0d released samples expected 0", rel); end
    endtask

    // locked low for one period during the stable count: the sequencer sees it at
    // edge 12, waits one cycle, re-enters S_STABLE at 13 and needs 8 fresh cycles.
    task automatic test_glitch();
        int t_mem, t_core, t_cpu;
        t_mem = -1; t_core = -1; t_cpu = -1;
        locked = 1'b1;
        apply_reset();
        for (int i = 1; i <= 35; i++) begin
            step();
            if (t_mem < 0 && rst_mem_n) t_mem = i;
            if (t_core < 0 && rst_core_n) t_core = i;
            if (t_cpu < 0 && rst_cpu_n) t_cpu = i;
            if (i == 9) locked = 1'b0;
            if (i == 10) locked = 1'b1;
        end
        n_tests++; if (t_mem !== 21) begin n_fail++; $display("FAIL glitch_mem_rise: got edge %0d expected 21", t_mem); end
        n_tests++; if (t_core !== 25) begin n_fail++; $display("FAIL glitch_core_rise: got edge %0d expected 25", t_core); end
        n_tests++; if (t_cpu !== 29) begin n_fail++; $display("FAIL glitch_cpu_rise: got edge %0d expected 29", t_cpu); end
    endtask

    // Lock loss in S_RUN: two synchronizer edges plus one FSM edge, then a full re-run.
    task automatic test_lock_loss_run();
        int t_low, t_mem, t_core, t_cpu;
        t_low = -1; t_mem = -1; t_core = -1; t_cpu = -1;
        boot_to_run();
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL loss_pre_ready: got %b expected 1", ready); end
        locked = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (!rst_mem_n && !rst_core_n && !rst_cpu_n && !ready) begin
                t_low = i;
                break;
            end
        end
        n_tests++; if (t_low !== 3) begin n_fail++; $display("FAIL loss_all_low: got edge %0d expected 3", t_low); end
        n_tests++; if (relock_cnt !== 8'd1) begin n_fail++; $display("FAIL loss_relock_cnt: got %0d expected 1", relock_cnt); end
        locked = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            step();
            if (t_mem < 0 && rst_mem_n) t_mem = i;
            if (t_core < 0 && rst_core_n) t_core = i;
            if (t_cpu < 0 && rst_cpu_n) t_cpu = i;
        end
        n_tests++; if (t_mem !== 11) begin n_fail++; $display("FAIL relock_mem_rise: got edge %0d expected 11", t_mem); end
        n_tests++; if (t_core !== 15) begin n_fail++; $display("FAIL relock_core_rise: got edge %0d expected 15", t_core); end
        n_tests++; if (t_cpu !== 19) begin n_fail++; $display("FAIL relock_cpu_rise: got edge %0d expected 19", t_cpu); end
    endtask

    // Soft reset from S_RUN, then a second one taken while in S_CORE.
    task automatic test_soft_reset();
        int core_r0, core_f, core_r1, cpu_r, mem_low;
        logic prev_core;
        core_r0 = -1; core_f = -1; core_r1 = -1; cpu_r = -1; mem_low = 0;
        boot_to_run();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        n_tests++; if (rst_core_n !== 1'b0) begin n_fail++; $display("FAIL soft_core_low: got %b expected 0", rst_core_n); end
        n_tests++; if (rst_cpu_n !== 1'b0) begin n_fail++; $display("FAIL soft_cpu_low: got %b expected 0", rst_cpu_n); end
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL soft_ready_low: got %b expected 0", ready); end
        n_tests++; if (rst_mem_n !== 1'b1) begin n_fail++; $display("FAIL soft_mem_high: got %b expected 1", rst_mem_n); end
        prev_core = rst_core_n;
        for (int j = 2; j <= 20; j++) begin
            step();
            if (!prev_core && rst_core_n) begin
                if (core_r0 < 0) core_r0 = j; else if (core_r1 < 0) core_r1 = j;
            end
            if (prev_core && !rst_core_n && core_f < 0) core_f = j;
            prev_core = rst_core_n;
            if (cpu_r < 0 && rst_cpu_n) cpu_r = j;
            if (!rst_mem_n) mem_low++;
            sw_rst_req = (j == 6);
        end
        sw_rst_req = 1'b0;
        n_tests++; if (core_r0 !== 5) begin n_fail++; $display("FAIL soft_core_rise: got edge %0d expected 5", core_r0); end
        n_tests++; if (core_f !== 7) begin n_fail++; $display("FAIL soft_core_refall: got edge %0d expected 7", core_f); end
        n_tests++; if (core_r1 !== 11) begin n_fail++; $display("FAIL soft_core_rerise: got edge %0d expected 11", core_r1); end
        n_tests++; if (cpu_r !== 15) begin n_fail++; $display("FAIL soft_cpu_rise: got edge %0d expected 15", cpu_r); end
        n_tests++; if (mem_low !== 0) begin n_fail++; $display("FAIL soft_mem_stays: got %0d low samples expected 0", mem_low); end
    endtask

    // Soft reset and synchronized lock loss land on the same S_RUN edge.
    task automatic test_simultaneous();
        boot_to_run();
        locked = 1'b0;
        step();
        step();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        n_tests++; if (rst_mem_n !== 1'b0) begin n_fail++; $display("FAIL simul_mem_low: got %b expected 0", rst_mem_n); end
        n_tests++; if (rst_core_n !== 1'b0) begin n_fail++; $display("FAIL simul_core_low: got %b expected 0", rst_core_n); end
        n_tests++; if (rst_cpu_n !== 1'b0) begin n_fail++; $display("FAIL simul_cpu_low: got %b expected 0", rst_cpu_n); end
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL simul_ready_low: got %b expected 0", ready); end
        n_tests++; if (relock_cnt !== 8'd1) begin n_fail++; $display("FAIL simul_relock_cnt: got %0d expected 1", relock_cnt); end
        locked = 1'b1;
    endtask

    // 300 lock losses from S_RUN: the counter must stop at 255.
    task automatic test_saturation();
        int got254, timeouts, waited;
        got254 = -1; timeouts = 0;
        boot_to_run();
        for (int k = 1; k <= 300; k++) begin
            locked = 1'b0;
            repeat (3) step();
            if (k == 254) got254 = int'(relock_cnt);
            locked = 1'b1;
            waited = 0;
            while (!ready && waited < 60) begin
                step();
                waited++;
            end
            if (!ready) begin
                timeouts++;
                break;
            end
        end
        n_tests++; if (timeouts !== 0) begin n_fail++; $display("FAIL sat_relock_wait: got %0d timeouts expected 0", timeouts); end
        n_tests++; if (got254 !== 254) begin n_fail++; $display("FAIL sat_count_254: got %0d expected 254", got254); end
        n_tests++; if (relock_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_count_300: got %0d expected 255", relock_cnt); end
    endtask

    // rst_n dropped mid-cycle in S_RUN: outputs must change before the next edge.
    task automatic test_async_reset();
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL async_pre_ready: got %b expected 1", ready); end
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL async_pll_rst: got %b expected 1", pll_rst); end
        n_tests++; if ({rst_mem_n, rst_core_n, rst_cpu_n} !== 3'b000) begin n_fail++; $display("FAIL async_resets: got %b expected 000", {rst_mem_n, rst_core_n, rst_cpu_n}); end
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL async_ready: got %b expected 0", ready); end
        n_tests++; if (relock_cnt !== 8'd0) begin n_fail++; $display("FAIL async_relock: got %0d expected 0", relock_cnt); end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_cold_boot(1'b0);
        test_cold_boot(1'b1);
        test_lock_timeout();
        test_glitch();
        test_lock_loss_run();
        test_soft_reset();
        test_simultaneous();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 SHALL have parameter LOCK_STABLE, default 1024, meaning consecutive synchronized-locked cycles required before reset release.
REQ-002 SHALL have parameter STAGE_GAP, default 256, meaning cycles between successive reset-stage releases.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 1048576, meaning cycles allowed in S_WAIT before re-resetting the PLL.
REQ-004 SHALL have parameter PLL_RST_CYCLES, default 16, meaning width of the pll_rst pulse.
REQ-005 SHALL have port clk, input, 1, the single system clock (PLL 80 MHz output); all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, the reset; it is asynchronous and active-low.
REQ-007 SHALL have port locked, input, 1, PLL lock status; it is asynchronous to clk.
REQ-008 SHALL have port sw_rst_req, input, 1, single-cycle soft-reset request; it is synchronous to clk.
REQ-009 SHALL have port pll_rst, output, 1, active-high reset to the PLL.
REQ-010 SHALL have ports rst_mem_n, rst_core_n and rst_cpu_n, output, 1 each, the staged active-low resets.
REQ-011 SHALL have port ready, output, 1, high only in S_RUN.
REQ-012 SHALL have port relock_cnt, output, 8, saturating count of lock losses seen in S_RUN.

Function
REQ-013 SHALL pass locked through a 2-flop synchronizer (locked_s); no other logic samples locked directly.
REQ-014 SHALL implement the states S_PLLRST, S_WAIT, S_STABLE, S_MEM, S_CORE and S_RUN.
REQ-015 SHALL, in S_PLLRST, hold pll_rst=1 for exactly PLL_RST_CYCLES cycles, then enter S_WAIT.
REQ-016 SHALL, in S_WAIT, enter S_STABLE when locked_s=1, and return to S_PLLRST when the wait count reaches LOCK_TIMEOUT-1.
REQ-017 SHALL, in S_STABLE, count consecutive locked_s=1 cycles; at LOCK_STABLE cycles enter S_MEM; any locked_s=0 clears the count and returns to S_WAIT.
REQ-018 SHALL, on entering S_MEM, deassert rst_mem_n; after STAGE_GAP cycles enter S_CORE.
REQ-019 SHALL, on entering S_CORE, deassert rst_core_n; after STAGE_GAP cycles enter S_RUN.
REQ-020 SHALL, on entering S_RUN, deassert rst_cpu_n and assert ready.
REQ-021 SHALL make all outputs registered; each reset output changes on the same edge as its state transition.
REQ-022 SHALL, on locked_s=0 in S_MEM, S_CORE or S_RUN, assert all three resets and clear ready on the next edge, then enter S_WAIT.
REQ-023 SHALL increment relock_cnt on a lock loss taken from S_RUN, saturating at 255.
REQ-024 SHALL, on sw_rst_req=1 in S_CORE or S_RUN, assert rst_core_n and rst_cpu_n, clear ready, and enter S_MEM with its gap counter cleared; rst_mem_n stays deasserted.
REQ-025 SHALL ignore sw_rst_req in S_PLLRST, S_WAIT, S_STABLE and S_MEM.
REQ-026 SHALL give lock loss priority when lock loss and sw_rst_req occur in the same cycle; relock_cnt still increments if the state is S_RUN.
REQ-027 SHALL size all counters at 20 bits, shared across states and cleared on every state change.
REQ-028 SHALL make the release order strictly mem, then core, then cpu; no path releases core before mem or cpu before core.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force: state=S_PLLRST, counters=0, synchronizer flops=0, pll_rst=1, rst_mem_n=rst_core_n=rst_cpu_n=0, ready=0, relock_cnt=0.
REQ-030 SHALL, after rst_n rises, start the PLL_RST_CYCLES count on the first clk edge.
REQ-031 SHALL apply the full forced values immediately when rst_n is asserted mid-sequence, from any state.

Structure
REQ-032 SHALL define the state enum, the counter width constant (20) and the parameter defaults in the shared package pll_rst_pkg.
REQ-033 SHALL implement the 2-flop synchronizer as the sub-module sync_2ff (async active-low reset, reset value 0); the rest is one FSM plus counter.

Verification (LOCK_STABLE=8, STAGE_GAP=4, LOCK_TIMEOUT=64, PLL_RST_CYCLES=4)
REQ-034 SHALL cover cold boot: release rst_n with locked=1 held -> pll_rst high for 4 cycles; rst_mem_n, rst_core_n and rst_cpu_n rise at 4-cycle spacing; ready=1 together with rst_cpu_n.
REQ-035 SHALL cover lock timeout: locked held 0 -> pll_rst re-pulses every 4+64 cycles; no reset output is ever released.
REQ-036 SHALL cover glitch: locked drops for 1 cycle after 5 stable cycles -> stable count restarts; rst_mem_n is delayed by the full 8 extra cycles.
REQ-037 SHALL cover lock loss in S_RUN: locked=0 -> all resets low and ready=0 within 3 clocks of the drop; relock_cnt goes 0->1; the sequence re-runs on relock.
REQ-038 SHALL cover soft reset: sw_rst_req pulse in S_RUN -> core and cpu reset low on the next edge, mem stays high; core releases 4 cycles later and cpu 4 cycles after that.
REQ-039 SHALL cover simultaneous events: sw_rst_req and lock loss in the same S_RUN cycle -> lock-loss path taken (all three resets low, relock_cnt+1); also 300 lock losses -> relock_cnt=255.
